// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared timing constants and helper functions for the VGA raster generator.
//   - DEF_* : default 640x480@72Hz mode (front porch, sync, back porch, active)
//   - axis_blank / axis_total : derive blanking length and line/frame totals
//   - fits_width : true when a total fits a counter of the given width
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 24;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 128;

    // Vertical timing, in lines
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 9;
    localparam int unsigned DEF_V_SYNC   = 3;
    localparam int unsigned DEF_V_BP     = 28;

    localparam int unsigned DEF_COORD_W  = 10;
    localparam int unsigned DEF_FRAME_W  = 8;

    // Blanking length of one axis: everything ahead of the visible region.
    function automatic int unsigned axis_blank(input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return fp + sync + bp;
    endfunction

    // Full period of one axis.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return axis_blank(fp, sync, bp) + active;
    endfunction

    // A counter of 'width' bits can address 0..total-1 when total <= 2^width.
    function automatic bit fits_width(input int unsigned total,
                                      input int unsigned width);
        return 64'(total) <= (64'd1 << width);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//
// Bundle between the raster timing generator and the pixel-generation logic.
//   px_en       : pixel advance enable (consumer -> generator)
//   resync      : restart raster at (0,0) (consumer -> generator)
//   hsync/vsync : sync pulses, polarity set by the generator parameters
//   activevideo : visible-area flag
//   x_px/y_px   : visible column/row, 0 outside the visible area
//   line_start  : one-clock pulse at the start of each line
//   frame_start : one-clock pulse at the start of each frame
//   frame_cnt   : completed-frame count
// Modports: master = generator side, slave = pixel-logic side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned FRAME_W = 8
);

    logic               px_en;
    logic               resync;
    logic               hsync;
    logic               vsync;
    logic               activevideo;
    logic [COORD_W-1:0] x_px;
    logic [COORD_W-1:0] y_px;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  px_en,
        input  resync,
        output hsync,
        output vsync,
        output activevideo,
        output x_px,
        output y_px,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output px_en,
        output resync,
        input  hsync,
        input  vsync,
        input  activevideo,
        input  x_px,
        input  y_px,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//
// One raster axis: a 0..TOTAL-1 wrap counter with sync and active decode.
// The axis order is front porch, sync, back porch, then the visible region.
//   clk, reset : clock and synchronous active-high reset
//   en         : advance one position
//   load0      : force the count to 0 (wins over en)
//   wrap       : en on the last position without load0 (a natural wrap)
//   is_zero    : count is 0
//   sync       : FP <= count < FP+SYNC (raw, active high)
//   active     : count >= BLANK
//   pos        : count - BLANK inside the visible region, else 0
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int unsigned TOTAL = 832,
    parameter int unsigned FP    = 24,
    parameter int unsigned SYNC  = 40,
    parameter int unsigned BLANK = 192,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load0,
    output logic         wrap,
    output logic         is_zero,
    output logic         sync,
    output logic         active,
    output logic [W-1:0] pos
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(FP);
    localparam logic [W-1:0] SYNC_HI = W'(FP + SYNC);
    localparam logic [W-1:0] BLANK_W = W'(BLANK);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (load0) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap    = en & at_last & ~load0;
    assign is_zero = (cnt_q == '0);
    assign sync    = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);
    assign active  = (cnt_q >= BLANK_W);
    assign pos     = active ? (cnt_q - BLANK_W) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator (default 640x480@72Hz).
// Two chained axis counters track the raster position (hc, vc); a single
// output register stage loads the decode of the current position on every
// px_en cycle, so all outputs lag the counters by one enabled pixel.
//   px_clk : sole clock
//   reset  : synchronous, active high; takes priority over resync
//   vga    : master side of vga_timing_gen_if (px_en/resync in, timing out)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COORD_W   = DEF_COORD_W,
    parameter int unsigned FRAME_W   = DEF_FRAME_W
) (
    input logic              px_clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_BLANK = axis_blank(H_FP, H_SYNC, H_BP);
    localparam int unsigned V_BLANK = axis_blank(V_FP, V_SYNC, V_BP);
    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (!fits_width(H_TOTAL, COORD_W)) begin : g_h_width_check
        $error("vga_timing_gen: H_TOTAL %0d does not fit COORD_W %0d", H_TOTAL, COORD_W);
    end
    if (!fits_width(V_TOTAL, COORD_W)) begin : g_v_width_check
        $error("vga_timing_gen: V_TOTAL %0d does not fit COORD_W %0d", V_TOTAL, COORD_W);
    end

    logic px_en;
    logic resync;
    logic load0;

    assign px_en  = vga.px_en;
    assign resync = vga.resync;
    // resync only counts on an enabled pixel
    assign load0  = px_en & resync;

    // ---------------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------------
    logic               h_wrap;
    logic               h_zero;
    logic               h_sync;
    logic               h_active;
    logic [COORD_W-1:0] h_pos;
    logic               v_wrap;
    logic               v_zero;
    logic               v_sync;
    logic               v_active;
    logic [COORD_W-1:0] v_pos;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BLANK (H_BLANK),
        .W     (COORD_W)
    ) u_h_counter (
        .clk     (px_clk),
        .reset   (reset),
        .en      (px_en),
        .load0   (load0),
        .wrap    (h_wrap),
        .is_zero (h_zero),
        .sync    (h_sync),
        .active  (h_active),
        .pos     (h_pos)
    );

    // Vertical advances once per natural horizontal wrap; v_wrap is then
    // the natural wrap of the whole raster from the last pixel to (0,0).
    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BLANK (V_BLANK),
        .W     (COORD_W)
    ) u_v_counter (
        .clk     (px_clk),
        .reset   (reset),
        .en      (h_wrap),
        .load0   (load0),
        .wrap    (v_wrap),
        .is_zero (v_zero),
        .sync    (v_sync),
        .active  (v_active),
        .pos     (v_pos)
    );

    // ---------------------------------------------------------------------
    // Output register stage
    // ---------------------------------------------------------------------
    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               activevideo_q, activevideo_d;
    logic [COORD_W-1:0] x_px_q,        x_px_d;
    logic [COORD_W-1:0] y_px_q,        y_px_d;
    logic               line_start_q,  line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q,   frame_cnt_d;
    // Set when the counters reached (0,0) by a natural wrap rather than by
    // reset or resync; only such a frame start bumps frame_cnt.
    logic               nat_wrap_q,    nat_wrap_d;
    logic               in_active;

    assign in_active = h_active & v_active;

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        activevideo_d = activevideo_q;
        x_px_d        = x_px_q;
        y_px_d        = y_px_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        nat_wrap_d    = nat_wrap_q;
        if (px_en) begin
            hsync_d       = h_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = v_sync ? VSYNC_POL : ~VSYNC_POL;
            activevideo_d = in_active;
            x_px_d        = in_active ? h_pos : '0;
            y_px_d        = in_active ? v_pos : '0;
            line_start_d  = h_zero;
            frame_start_d = h_zero & v_zero;
            if (h_zero && v_zero && nat_wrap_q) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            nat_wrap_d    = v_wrap;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            activevideo_q <= 1'b0;
            x_px_q        <= '0;
            y_px_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            nat_wrap_q    <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            activevideo_q <= activevideo_d;
            x_px_q        <= x_px_d;
            y_px_q        <= y_px_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            nat_wrap_q    <= nat_wrap_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.activevideo = activevideo_q;
    assign vga.x_px        = x_px_q;
    assign vga.y_px        = y_px_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances: the default 640x480@72 mode (line-level timing, reset,
// px_en toggling) and a tiny high-polarity mode (H 8/2/2/2, V 4/1/1/1,
// 98 clocks per frame) for frame counting, resync and frame_cnt wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_d;
    logic rst_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.COORD_W(10), .FRAME_W(8)) vd ();
    vga_timing_gen_if #(.COORD_W(4),  .FRAME_W(8)) vs ();

    vga_timing_gen #(
        .COORD_W (10),
        .FRAME_W (8)
    ) u_dut_def (
        .px_clk (clk),
        .reset  (rst_d),
        .vga    (vd)
    );

    vga_timing_gen #(
        .H_ACTIVE  (8),
        .H_FP      (2),
        .H_SYNC    (2),
        .H_BP      (2),
        .V_ACTIVE  (4),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .HSYNC_POL (1'b1),
        .VSYNC_POL (1'b1),
        .COORD_W   (4),
        .FRAME_W   (8)
    ) u_dut_small (
        .px_clk (clk),
        .reset  (rst_s),
        .vga    (vs)
    );

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Measurement accumulators
    int hs_low0, hs_first, vs_low, vs_first, ls_cnt, ls_bad, fs_cnt;
    int act_cnt, act_first, x_bad, y_bad;
    int hs_low_t, hs_first_t, ls_t, ls_t_bad, hold_bad;
    int hs_hi, hs_hi_first, vs_hi, vs_hi_first, fs_bad;
    int hp, vp;
    logic [22:0] prev_out;
    logic [22:0] cur_out;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_d = 1'b1;
        rst_s = 1'b1;
        vd.px_en = 1'b0;
        vd.resync = 1'b0;
        vs.px_en = 1'b0;
        vs.resync = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        check_eq("rst_hsync",       int'(vd.hsync), 1);
        check_eq("rst_vsync",       int'(vd.vsync), 1);
        check_eq("rst_active",      int'(vd.activevideo), 0);
        check_eq("rst_x",           int'(vd.x_px), 0);
        check_eq("rst_y",           int'(vd.y_px), 0);
        check_eq("rst_line_start",  int'(vd.line_start), 0);
        check_eq("rst_frame_start", int'(vd.frame_start), 0);
        check_eq("rst_frame_cnt",   int'(vd.frame_cnt), 0);
        check_eq("rst_small_hsync", int'(vs.hsync), 0);
        check_eq("rst_small_vsync", int'(vs.vsync), 0);

        // Default mode, px_en high: 42 lines, sample s shows hc=s%832, vc=s/832
        hs_low0 = 0; hs_first = -1; vs_low = 0; vs_first = -1;
        ls_cnt = 0; ls_bad = 0; fs_cnt = 0;
        act_cnt = 0; act_first = -1; x_bad = 0; y_bad = 0;
        rst_d = 1'b0;
        vd.px_en = 1'b1;
        for (int s = 0; s < 42 * 832; s++) begin
            @(negedge clk);
            hp = s % 832;
            vp = s / 832;
            if (!vd.hsync) begin
                if (vp == 0) hs_low0++;
                if (hs_first < 0) hs_first = s;
            end
            if (!vd.vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = s;
            end
            if (vd.line_start) begin
                ls_cnt++;
                if (hp != 0) ls_bad++;
            end
            if (vd.frame_start) fs_cnt++;
            if (vd.activevideo) begin
                act_cnt++;
                if (act_first < 0) act_first = s;
                if (int'(vd.x_px) != hp - 192) x_bad++;
                if (int'(vd.y_px) != vp - 40) y_bad++;
            end else if (vd.x_px != 0 || vd.y_px != 0) begin
                x_bad++;
            end
        end
        check_eq("hsync_low_per_line",  hs_low0, 40);
        check_eq("hsync_first_low",     hs_first, 24);
        check_eq("vsync_low_clocks",    vs_low, 3 * 832);
        check_eq("vsync_first_low",     vs_first, 9 * 832);
        check_eq("line_start_count",    ls_cnt, 42);
        check_eq("line_start_misplace", ls_bad, 0);
        check_eq("frame_start_count",   fs_cnt, 1);
        check_eq("active_clocks",       act_cnt, 2 * 640);
        check_eq("active_first",        act_first, 40 * 832 + 192);
        check_eq("x_px_sequence",       x_bad, 0);
        check_eq("y_px_sequence",       y_bad, 0);

        // Mid-active: line 42, hc 299
        repeat (300) @(negedge clk);
        check_eq("mid_active", int'(vd.activevideo), 1);
        check_eq("mid_x",      int'(vd.x_px), 107);
        check_eq("mid_y",      int'(vd.y_px), 2);
        check_eq("mid_fcnt",   int'(vd.frame_cnt), 0);

        // Reset with resync also high
        rst_d = 1'b1;
        vd.resync = 1'b1;
        @(negedge clk);
        check_eq("rr_x",           int'(vd.x_px), 0);
        check_eq("rr_y",           int'(vd.y_px), 0);
        check_eq("rr_active",      int'(vd.activevideo), 0);
        check_eq("rr_hsync",       int'(vd.hsync), 1);
        check_eq("rr_vsync",       int'(vd.vsync), 1);
        check_eq("rr_frame_cnt",   int'(vd.frame_cnt), 0);
        check_eq("rr_line_start",  int'(vd.line_start), 0);

        // px_en toggling every cycle: output hc = s/2
        rst_d = 1'b0;
        vd.resync = 1'b0;
        vd.px_en = 1'b1;
        hs_low_t = 0; hs_first_t = -1; ls_t = 0; ls_t_bad = 0; hold_bad = 0;
        prev_out = '0;
        for (int s = 0; s < 2 * 2 * 832; s++) begin
            @(negedge clk);
            cur_out = {vd.hsync, vd.vsync, vd.activevideo, vd.x_px, vd.y_px};
            if (s == 0) begin
                check_eq("restart_line_start",  int'(vd.line_start), 1);
                check_eq("restart_frame_start", int'(vd.frame_start), 1);
            end
            if (s == 1) check_eq("line_start_one_clk", int'(vd.line_start), 0);
            if ((s % 2 == 1) && (cur_out != prev_out)) hold_bad++;
            if (!vd.hsync && s < 1664) begin
                hs_low_t++;
                if (hs_first_t < 0) hs_first_t = s;
            end
            if (vd.line_start) begin
                ls_t++;
                if (s % 1664 != 0) ls_t_bad++;
            end
            prev_out = cur_out;
            vd.px_en = ~vd.px_en;
        end
        check_eq("half_hsync_low",       hs_low_t, 80);
        check_eq("half_hsync_first",     hs_first_t, 48);
        check_eq("half_line_start_cnt",  ls_t, 2);
        check_eq("half_line_start_pos",  ls_t_bad, 0);
        check_eq("half_hold",            hold_bad, 0);
        vd.px_en = 1'b1;

        // Small mode, high-active syncs: sample s shows position s%98
        hs_hi = 0; hs_hi_first = -1; vs_hi = 0; vs_hi_first = -1; fs_bad = 0;
        rst_s = 1'b0;
        vs.px_en = 1'b1;
        for (int s = 0; s <= 25168; s++) begin
            @(negedge clk);
            if (s < 14 && vs.hsync) begin
                hs_hi++;
                if (hs_hi_first < 0) hs_hi_first = s;
            end
            if (s < 98 && vs.vsync) begin
                vs_hi++;
                if (vs_hi_first < 0) vs_hi_first = s;
            end
            if (s > 374 && s < 472 && vs.frame_start) fs_bad++;
            case (s)
                0: begin
                    check_eq("sm_fs_first",  int'(vs.frame_start), 1);
                    check_eq("sm_fcnt_first", int'(vs.frame_cnt), 0);
                end
                90: begin
                    check_eq("sm_active_90", int'(vs.activevideo), 1);
                    check_eq("sm_x_90",      int'(vs.x_px), 0);
                    check_eq("sm_y_90",      int'(vs.y_px), 3);
                end
                97: begin
                    check_eq("sm_x_97",    int'(vs.x_px), 7);
                    check_eq("sm_fcnt_97", int'(vs.frame_cnt), 0);
                end
                98: begin
                    check_eq("sm_fs_98",   int'(vs.frame_start), 1);
                    check_eq("sm_fcnt_98", int'(vs.frame_cnt), 1);
                end
                196: check_eq("sm_fcnt_196", int'(vs.frame_cnt), 2);
                373: begin
                    check_eq("rs_pre_x",    int'(vs.x_px), 3);
                    check_eq("rs_pre_y",    int'(vs.y_px), 2);
                    check_eq("rs_pre_fcnt", int'(vs.frame_cnt), 3);
                end
                374: begin
                    check_eq("rs_fs",     int'(vs.frame_start), 1);
                    check_eq("rs_ls",     int'(vs.line_start), 1);
                    check_eq("rs_active", int'(vs.activevideo), 0);
                    check_eq("rs_fcnt",   int'(vs.frame_cnt), 3);
                end
                471: check_eq("rs_fcnt_hold", int'(vs.frame_cnt), 3);
                472: begin
                    check_eq("rs_next_fs",   int'(vs.frame_start), 1);
                    check_eq("rs_next_fcnt", int'(vs.frame_cnt), 4);
                end
                25167: check_eq("fcnt_max", int'(vs.frame_cnt), 255);
                25168: begin
                    check_eq("fcnt_wrap_fs", int'(vs.frame_start), 1);
                    check_eq("fcnt_wrap",    int'(vs.frame_cnt), 0);
                end
                default: ;
            endcase
            if (s == 372) vs.resync = 1'b1;
            if (s == 373) vs.resync = 1'b0;
        end
        check_eq("sm_hsync_high",       hs_hi, 2);
        check_eq("sm_hsync_first",      hs_hi_first, 2);
        check_eq("sm_vsync_high",       vs_hi, 14);
        check_eq("sm_vsync_first",      vs_hi_first, 14);
        check_eq("rs_no_early_fs",      fs_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for 640x480@72Hz and any other mode set through parameters.
- Drives sync pulses, active-video flag, pixel coordinates, line/frame strobes and a frame counter to the pixel-generation logic.
- A pixel-clock enable lets it run from a clock faster than the pixel rate.
- A resync input realigns the raster to an external event.
- Generalises the existing fixed-mode sync generator; line order is front porch, sync, back porch, then active.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 40, hsync pulse width
- `H_BP`, 128, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 9, vertical front porch (lines)
- `V_SYNC`, 3, vsync pulse width
- `V_BP`, 28, vertical back porch
- `HSYNC_POL`, 0, hsync active level (0 = active low)
- `VSYNC_POL`, 0, vsync active level
- `COORD_W`, 10, counter/coordinate width; H/V totals must be ≤ 2^COORD_W
- `FRAME_W`, 8, frame counter width
- `px_clk` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `px_en` in 1: pixel advance enable; tie high for one pixel per clock
- `resync` in 1: restart raster at (0,0)
- `hsync` out 1: horizontal sync, polarity per `HSYNC_POL`
- `vsync` out 1: vertical sync, polarity per `VSYNC_POL`
- `activevideo` out 1: high while in visible area
- `x_px` out COORD_W: visible column, 0..H_ACTIVE-1
- `y_px` out COORD_W: visible row, 0..V_ACTIVE-1
- `line_start` out 1: one-clock pulse at start of each line
- `frame_start` out 1: one-clock pulse at start of each frame
- `frame_cnt` out FRAME_W: completed-frame count

## Operation
- Derived totals:
  - `H_BLANK = H_FP+H_SYNC+H_BP`
  - `V_BLANK = V_FP+V_SYNC+V_BP`
  - `H_TOTAL = H_BLANK+H_ACTIVE`
  - `V_TOTAL = V_BLANK+V_ACTIVE`
- Internal counters `hc` (0..H_TOTAL-1) and `vc` (0..V_TOTAL-1) advance only on `px_en` cycles.
  - `hc` wraps to 0 after H_TOTAL-1.
  - `vc` increments on each `hc` wrap and wraps to 0 after V_TOTAL-1.
- Decode of position (hc, vc):
  - Sync asserted for `H_FP ≤ hc < H_FP+H_SYNC` (likewise vsync on vc).
  - Active when `hc ≥ H_BLANK && vc ≥ V_BLANK`.
  - `x_px = hc-H_BLANK` and `y_px = vc-V_BLANK` when active, otherwise 0. Computed modulo 2^COORD_W.
- `frame_cnt` increments, wrapping mod 2^FRAME_W, only on the natural wrap of (hc, vc) from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- `resync`, when sampled high on a `px_en` cycle, loads hc = vc = 0 in place of the normal increment.
  - `frame_cnt` is unchanged by a resync.
  - `resync` is ignored when `px_en` is low.
- Priority: `reset` > `resync` > normal count.
- Reset values:
  - hc, vc, `x_px`, `y_px`, `frame_cnt` = 0
  - `hsync` = !HSYNC_POL, `vsync` = !VSYNC_POL
  - `activevideo`, `line_start`, `frame_start` = 0
- No other state machine: the raster is the two chained counters plus one output register stage.

## Timing
- All outputs registered. On each `px_en` cycle the output stage loads the decode of the current (hc, vc) while the counters advance.
  - Outputs therefore lag the counters by one enabled pixel.
  - `hsync`, `vsync`, `activevideo`, `x_px`, `y_px` stay mutually aligned and hold between `px_en` cycles.
- `line_start` is high for exactly one `px_clk` cycle: the cycle after a `px_en` load of a position with hc == 0.
- `frame_start` is likewise high for one cycle on a load of hc == 0 and vc == 0. It coincides with `line_start`.
- `frame_cnt` updates in the same cycle as the `frame_start` caused by a natural wrap.
- After reset is released with `px_en` held high:
  - The first output load (first enabled cycle) presents position (0,0).
  - `line_start` and `frame_start` therefore pulse in the following cycle.
- Reset mid-frame: all outputs take reset values in the next cycle; counting resumes from (0,0).

## Structure
- Package `vga_timing_pkg`:
  - Default 640x480@72 timing constants.
  - Derived-total and width-check functions (elaboration error if totals exceed 2^COORD_W).
- One sub-module, `vga_axis_counter`: a wrap counter with `en`, `load0`, wrap output, and sync/active decode.
  - Instantiated twice: horizontal counter, then vertical counter enabled by the horizontal wrap.

## Test plan
- Defaults, `px_en` = 1, reset released:
  - `hsync` low for exactly 40 clocks per 832-clock line, starting at output position hc = 24.
  - `activevideo` high for 640 clocks per line with `x_px` 0..639.
- Full frame:
  - `vsync` low for 3 lines per 520-line frame.
  - `frame_start` period = 432640 clocks; `frame_cnt` increments 0→1→2.
  - `y_px` runs 0..479 over active lines.
- `px_en` toggled 1/0 every other cycle:
  - All periods double; outputs hold during disabled cycles.
  - `line_start` still lasts exactly 1 clock.
- `resync` pulsed at mid-frame (vc = 300, hc = 500):
  - Next load presents (0,0) and `frame_start` pulses.
  - `frame_cnt` is unchanged.
  - Next natural wrap follows 432640 enabled clocks later.
- `reset` asserted mid-active with `resync` also high:
  - Next cycle: `x_px` = `y_px` = 0, `activevideo` = 0, syncs inactive, `frame_cnt` = 0.
- `HSYNC_POL` = `VSYNC_POL` = 1 with small mode (H: 8/2/2/2, V: 4/1/1/1):
  - Syncs are high-active; `hsync` high for 2 of 14 clocks.
  - `frame_cnt` wraps at 2^FRAME_W frames.
